// File: rtl/eth_defs.sv
// Ethernet/IPv4/UDP constants, FSM encodings and the byte-wide CRC-32 step.
// The GMII transmit and receive paths both use this package.
package eth_defs;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  localparam logic [15:0] ETH_HDR_LEN   = 16'd14;
  localparam logic [15:0] IP_HDR_LEN    = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [15:0] PREAMBLE_MAX  = 16'd7;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_ETH_HDR  = 3'd2;
  localparam logic [2:0] ST_IP_HDR   = 3'd3;
  localparam logic [2:0] ST_UDP_HDR  = 3'd4;
  localparam logic [2:0] ST_PAYLOAD  = 3'd5;
  localparam logic [2:0] ST_DRAIN    = 3'd6;
  localparam logic [2:0] ST_REPORT   = 3'd7;

  // One byte of CRC-32. The register is kept MSB-first while the byte is
  // consumed LSB-first, which equals the reflected Ethernet CRC bit-reversed;
  // in this orientation a frame followed by its FCS leaves C704DD7B.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide registered CRC-32 (Ethernet polynomial) with init and enable.
// init takes priority over en.
module crc32_d8
  import eth_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  // CRC register: reload on init, fold in one byte per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc32_next(crc, data);
  end

endmodule

// File: rtl/gmii_udp_rx.sv
// GMII receive parser: strips preamble/SFD, filters MAC/IPv4/UDP port,
// streams the UDP payload with sof/eof and reports FCS/error status per frame.
module gmii_udp_rx
  import eth_defs::*;
#(
  parameter logic [47:0] LOCAL_MAC   = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP    = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT  = 16'd8080,
  parameter int          MAX_PAYLOAD = 1472
)
(
  input  logic        e_rxc,
  input  logic        rst_n,
  input  logic        e_rxdv,
  input  logic        e_rxer,
  input  logic [7:0]  e_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [15:0] rx_len,
  output logic        frame_done,
  output logic        frame_ok
);

  localparam logic [15:0] MAX_UDP_LEN = 16'(MAX_PAYLOAD + 8);

  logic [7:0]  d_reg;
  logic        dv_reg;
  logic        er_reg;
  logic        armed_reg;     // a dv=0 cycle has been seen since reset
  logic [2:0]  state_reg;
  logic [15:0] cnt_reg;       // header byte index / preamble count / payload down-counter
  logic [39:0] sr_reg;        // last five received bytes for multi-byte field compares
  logic [15:0] len_reg;       // UDP length field
  logic        report_reg;    // frame reached payload stage, must be reported
  logic        complete_reg;  // whole payload was received
  logic        err_reg;       // sticky e_rxer during this frame

  logic [31:0] crc_val;
  logic        crc_init;
  logic        crc_en;
  logic [47:0] mac_field;
  logic [31:0] ip_field;
  logic [15:0] hdr_word;

  assign mac_field = {sr_reg[39:0], d_reg};
  assign ip_field  = {sr_reg[23:0], d_reg};
  assign hdr_word  = {sr_reg[7:0], d_reg};

  // CRC restarts before every SFD and covers every byte after it, FCS included
  assign crc_init = (state_reg == ST_IDLE) || (state_reg == ST_PREAMBLE);
  assign crc_en   = dv_reg && !crc_init && (state_reg != ST_REPORT);

  crc32_d8 u_crc (
    .clk   (e_rxc),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .data  (d_reg),
    .crc   (crc_val)
  );

  // Input register; armed blocks a frame already running when reset releases
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      d_reg     <= 8'h00;
      dv_reg    <= 1'b0;
      er_reg    <= 1'b0;
      armed_reg <= 1'b0;
      sr_reg    <= 40'h0;
    end else begin
      d_reg  <= e_rxd;
      dv_reg <= e_rxdv;
      er_reg <= e_rxer;
      sr_reg <= {sr_reg[31:0], d_reg};
      if (!e_rxdv) armed_reg <= 1'b1;
    end
  end

  // Frame parser FSM and registered outputs
  always_ff @(posedge e_rxc or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 16'd0;
      len_reg      <= 16'd0;
      report_reg   <= 1'b0;
      complete_reg <= 1'b0;
      err_reg      <= 1'b0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_sof       <= 1'b0;
      rx_eof       <= 1'b0;
      rx_len       <= 16'd0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      rx_sof     <= 1'b0;
      rx_eof     <= 1'b0;
      frame_done <= 1'b0;
      if (state_reg != ST_IDLE && state_reg != ST_REPORT && dv_reg && er_reg)
        err_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          report_reg   <= 1'b0;
          complete_reg <= 1'b0;
          err_reg      <= 1'b0;
          if (dv_reg && armed_reg) begin
            err_reg <= er_reg;
            if (d_reg == PREAMBLE_BYTE) begin
              cnt_reg   <= 16'd1;
              state_reg <= ST_PREAMBLE;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end
        end

        ST_REPORT: state_reg <= ST_IDLE;

        default: begin
          if (!dv_reg) begin
            // end of frame, whatever state it was in
            if (report_reg) begin
              state_reg  <= ST_REPORT;
              frame_done <= 1'b1;
              frame_ok   <= (crc_val == CRC_RESIDUE) && !err_reg && complete_reg;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            case (state_reg)
              ST_PREAMBLE: begin
                if (d_reg == PREAMBLE_BYTE) begin
                  if (cnt_reg == PREAMBLE_MAX) state_reg <= ST_DRAIN;
                  else                         cnt_reg   <= cnt_reg + 16'd1;
                end else if (d_reg == SFD_BYTE) begin
                  cnt_reg   <= 16'd0;
                  state_reg <= ST_ETH_HDR;
                end else begin
                  state_reg <= ST_DRAIN;
                end
              end

              ST_ETH_HDR: begin
                cnt_reg <= cnt_reg + 16'd1;
                if (cnt_reg == 16'd5 && mac_field != LOCAL_MAC && mac_field != 48'hFFFFFFFFFFFF)
                  state_reg <= ST_DRAIN;
                else if (cnt_reg == ETH_HDR_LEN - 16'd1) begin
                  cnt_reg   <= 16'd0;
                  state_reg <= (hdr_word == ETH_TYPE_IPV4) ? ST_IP_HDR : ST_DRAIN;
                end
              end

              ST_IP_HDR: begin
                cnt_reg <= cnt_reg + 16'd1;
                if (cnt_reg == 16'd0 && d_reg != IP_VER_IHL)
                  state_reg <= ST_DRAIN;
                else if (cnt_reg == 16'd9 && d_reg != IP_PROTO_UDP)
                  state_reg <= ST_DRAIN;
                else if (cnt_reg == IP_HDR_LEN - 16'd1) begin
                  cnt_reg   <= 16'd0;
                  state_reg <= (ip_field == LOCAL_IP) ? ST_UDP_HDR : ST_DRAIN;
                end
              end

              ST_UDP_HDR: begin
                cnt_reg <= cnt_reg + 16'd1;
                if (cnt_reg == 16'd3 && hdr_word != LOCAL_PORT)
                  state_reg <= ST_DRAIN;
                else if (cnt_reg == 16'd5) begin
                  len_reg <= hdr_word;
                  if (hdr_word < UDP_HDR_LEN || hdr_word > MAX_UDP_LEN)
                    state_reg <= ST_DRAIN;
                end else if (cnt_reg == UDP_HDR_LEN - 16'd1) begin
                  rx_len     <= len_reg - UDP_HDR_LEN;
                  cnt_reg    <= len_reg - UDP_HDR_LEN;
                  report_reg <= 1'b1;
                  if (len_reg == UDP_HDR_LEN) begin
                    complete_reg <= 1'b1;
                    state_reg    <= ST_DRAIN;
                  end else begin
                    state_reg <= ST_PAYLOAD;
                  end
                end
              end

              ST_PAYLOAD: begin
                rx_valid <= 1'b1;
                rx_data  <= d_reg;
                rx_sof   <= (cnt_reg == rx_len);
                rx_eof   <= (cnt_reg == 16'd1);
                cnt_reg  <= cnt_reg - 16'd1;
                if (cnt_reg == 16'd1) begin
                  complete_reg <= 1'b1;
                  state_reg    <= ST_DRAIN;
                end
              end

              default: ; // DRAIN: swallow padding and FCS until dv falls
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_udp_rx.sv
// Directed bench for gmii_udp_rx: builds frames with a reflected CRC-32 FCS,
// drives them on GMII and checks payload stream and frame status.
module tb_gmii_udp_rx;

  localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
  localparam logic [31:0] LIP   = 32'hC0A80002;
  localparam logic [15:0] LPORT = 16'd8080;
  localparam int          HDR   = 42;

  logic        e_rxc = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_rxdv = 1'b0;
  logic        e_rxer = 1'b0;
  logic [7:0]  e_rxd = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, frame_done, frame_ok;
  logic [15:0] rx_len;

  always #4 e_rxc = ~e_rxc;

  gmii_udp_rx dut (
    .e_rxc      (e_rxc),
    .rst_n      (rst_n),
    .e_rxdv     (e_rxdv),
    .e_rxer     (e_rxer),
    .e_rxd      (e_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .rx_len     (rx_len),
    .frame_done (frame_done),
    .frame_ok   (frame_ok)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // output monitor: running totals, sampled on the falling edge
  int cyc = 0;
  int vtot = 0, sof_tot = 0, eof_tot = 0, done_tot = 0, ok_tot = 0;
  int sof_cyc = 0;
  logic [7:0] eof_data = 8'h00;
  logic [7:0] sof_data = 8'h00;
  logic [7:0] cap [0:4095];

  always @(posedge e_rxc) cyc <= cyc + 1;

  always @(negedge e_rxc) begin
    if (rx_valid) begin
      cap[vtot % 4096] = rx_data;
      vtot++;
      if (rx_sof) begin sof_tot++; sof_cyc = cyc; sof_data = rx_data; end
      if (rx_eof) begin eof_tot++; eof_data = rx_data; end
    end
    if (frame_done) begin
      done_tot++;
      if (frame_ok) ok_tot++;
    end
  end

  // frame construction
  logic [7:0] fbuf [0:2047];
  logic [7:0] pay  [0:1599];
  int flen;
  int drive_cyc = 0;
  int v0, s0, e0, d0, o0;

  task automatic push(input logic [7:0] b);
    fbuf[flen] = b;
    flen++;
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, fbuf[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [31:0] dip,
                       input logic [15:0] dport, input int plen, input int pad_min);
    logic [15:0] iplen, udplen;
    logic [31:0] fcs;
    iplen  = 16'(28 + plen);
    udplen = 16'(8 + plen);
    flen = 0;
    for (int i = 5; i >= 0; i--) push(dmac[i*8 +: 8]);
    push(8'h02); push(8'h00); push(8'h00); push(8'h00); push(8'h00); push(8'h01);
    push(8'h08); push(8'h00);
    push(8'h45); push(8'h00); push(iplen[15:8]); push(iplen[7:0]);
    push(8'h00); push(8'h00); push(8'h40); push(8'h00);
    push(8'h40); push(8'h11); push(8'h00); push(8'h00);
    push(8'hC0); push(8'hA8); push(8'h00); push(8'h01);
    for (int i = 3; i >= 0; i--) push(dip[i*8 +: 8]);
    push(8'h04); push(8'hD2); push(dport[15:8]); push(dport[7:0]);
    push(udplen[15:8]); push(udplen[7:0]); push(8'h00); push(8'h00);
    for (int i = 0; i < plen; i++) push(pay[i]);
    while (flen < pad_min) push(8'h00);
    fcs = fcs_of(flen);
    push(fcs[7:0]); push(fcs[15:8]); push(fcs[23:16]); push(fcs[31:24]);
  endtask

  // drive preamble+SFD+frame; stop_at truncates, err_at pulses e_rxer,
  // reset_at pulses rst_n before that byte; then a 12-cycle IFG
  task automatic send(input int stop_at, input int err_at, input int reset_at);
    for (int i = 0; i < 8; i++) begin
      @(negedge e_rxc);
      e_rxdv = 1'b1; e_rxer = 1'b0;
      e_rxd  = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < flen; i++) begin
      if (i == stop_at) break;
      if (i == reset_at) begin
        @(posedge e_rxc);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_len",   32'(rx_len),   32'd0);
        check("rst_data",  32'(rx_data),  32'd0);
      end
      @(negedge e_rxc);
      if (i == reset_at + 2) rst_n = 1'b1;
      e_rxdv = 1'b1;
      e_rxd  = fbuf[i];
      e_rxer = (i == err_at);
      if (i == HDR) drive_cyc = cyc;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge e_rxc);
      e_rxdv = 1'b0; e_rxer = 1'b0; e_rxd = 8'h00;
    end
  endtask

  task automatic snap;
    v0 = vtot; s0 = sof_tot; e0 = eof_tot; d0 = done_tot; o0 = ok_tot;
  endtask

  initial begin
    // reset
    repeat (3) @(negedge e_rxc);
    check("reset_valid", 32'(rx_valid),   32'd0);
    check("reset_done",  32'(frame_done), 32'd0);
    check("reset_ok",    32'(frame_ok),   32'd0);
    check("reset_len",   32'(rx_len),     32'd0);
    check("reset_sofeof", 32'({rx_sof, rx_eof}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge e_rxc);

    // good frame 01..04
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
    build(LMAC, LIP, LPORT, 4, 0);
    snap();
    send(-1, -1, -1);
    $display("frame good4: valid=%0d done=%0d ok=%0d", vtot - v0, done_tot - d0, ok_tot - o0);
    check("good_nvalid", 32'(vtot - v0), 32'd4);
    for (int i = 0; i < 4; i++) check("good_data", 32'(cap[(v0 + i) % 4096]), 32'(i + 1));
    check("good_sof",     32'(sof_tot - s0), 32'd1);
    check("good_sofdata", 32'(sof_data),     32'h01);
    check("good_eof",     32'(eof_tot - e0), 32'd1);
    check("good_eofdata", 32'(eof_data),     32'h04);
    check("good_len",     32'(rx_len),       32'd4);
    check("good_latency", 32'(sof_cyc - drive_cyc), 32'd2);
    check("good_done",    32'(done_tot - d0), 32'd1);
    check("good_ok",      32'(ok_tot - o0),   32'd1);

    // bad FCS
    fbuf[flen - 1] = fbuf[flen - 1] ^ 8'hFF;
    snap();
    send(-1, -1, -1);
    $display("frame badfcs: valid=%0d done=%0d ok=%0d", vtot - v0, done_tot - d0, ok_tot - o0);
    check("badfcs_nvalid", 32'(vtot - v0),     32'd4);
    check("badfcs_done",   32'(done_tot - d0), 32'd1);
    check("badfcs_ok",     32'(ok_tot - o0),   32'd0);

    // wrong port, wrong IP
    build(LMAC, LIP, 16'd8081, 4, 0);
    snap();
    send(-1, -1, -1);
    $display("frame port8081: valid=%0d done=%0d", vtot - v0, done_tot - d0);
    check("port_nvalid", 32'(vtot - v0),     32'd0);
    check("port_done",   32'(done_tot - d0), 32'd0);
    build(LMAC, 32'hC0A80003, LPORT, 4, 0);
    snap();
    send(-1, -1, -1);
    $display("frame ip.3: valid=%0d done=%0d", vtot - v0, done_tot - d0);
    check("ip_nvalid", 32'(vtot - v0),     32'd0);
    check("ip_done",   32'(done_tot - d0), 32'd0);

    // minimum frame with padding, broadcast destination
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    build(48'hFFFFFFFFFFFF, LIP, LPORT, 2, 60);
    snap();
    send(-1, -1, -1);
    $display("frame min60: valid=%0d done=%0d ok=%0d", vtot - v0, done_tot - d0, ok_tot - o0);
    check("min_nvalid",  32'(vtot - v0),          32'd2);
    check("min_data0",   32'(cap[v0 % 4096]),     32'hAA);
    check("min_eofdata", 32'(eof_data),           32'hBB);
    check("min_len",     32'(rx_len),             32'd2);
    check("min_ok",      32'(ok_tot - o0),        32'd1);

    // truncated after 10 of 100 payload bytes
    for (int i = 0; i < 100; i++) pay[i] = 8'(i + 16);
    build(LMAC, LIP, LPORT, 100, 0);
    snap();
    send(HDR + 10, -1, -1);
    $display("frame trunc: valid=%0d eof=%0d done=%0d ok=%0d", vtot - v0, eof_tot - e0, done_tot - d0, ok_tot - o0);
    check("trunc_nvalid", 32'(vtot - v0),     32'd10);
    check("trunc_eof",    32'(eof_tot - e0),  32'd0);
    check("trunc_done",   32'(done_tot - d0), 32'd1);
    check("trunc_ok",     32'(ok_tot - o0),   32'd0);

    // e_rxer pulsed mid-payload
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
    build(LMAC, LIP, LPORT, 4, 0);
    snap();
    send(-1, HDR + 1, -1);
    $display("frame rxer: valid=%0d done=%0d ok=%0d", vtot - v0, done_tot - d0, ok_tot - o0);
    check("rxer_nvalid", 32'(vtot - v0),     32'd4);
    check("rxer_done",   32'(done_tot - d0), 32'd1);
    check("rxer_ok",     32'(ok_tot - o0),   32'd0);

    // reset asserted mid-payload; rest of that frame must be ignored
    for (int i = 0; i < 20; i++) pay[i] = 8'(i + 1);
    build(LMAC, LIP, LPORT, 20, 0);
    snap();
    send(-1, -1, HDR + 8);
    $display("frame reset: done=%0d", done_tot - d0);
    check("rstframe_done", 32'(done_tot - d0), 32'd0);

    // next good frame after IFG
    for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
    build(LMAC, LIP, LPORT, 4, 0);
    snap();
    send(-1, -1, -1);
    $display("frame after_reset: valid=%0d ok=%0d", vtot - v0, ok_tot - o0);
    check("after_nvalid", 32'(vtot - v0),   32'd4);
    check("after_ok",     32'(ok_tot - o0), 32'd1);

    // two back-to-back good frames with 12-byte IFG
    snap();
    send(-1, -1, -1);
    send(-1, -1, -1);
    $display("frames b2b: valid=%0d done=%0d ok=%0d", vtot - v0, done_tot - d0, ok_tot - o0);
    check("b2b_nvalid", 32'(vtot - v0),     32'd8);
    check("b2b_done",   32'(done_tot - d0), 32'd2);
    check("b2b_ok",     32'(ok_tot - o0),   32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
